// File: rtl/test_sequencer.sv
// Run controller: steps test index 0..NUM_TESTS-1, launches each test, collects verdicts.
// Latency: start accepted at edge 0; test i issues at cycle 3i (plus extra WAIT cycles); done at 3*NUM_TESTS.
// Backpressure: none; waits on dut_done per test, bounded by a TIMEOUT-cycle watchdog.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   start                    run request, honoured only while idle
//   test, dut_start          current test index and one-cycle launch pulse to the DUT
//   dut_done, dut_pass       DUT completion strobe and verdict (verdict valid with done)
//   busy, done, result       run status; result valid while done=1
//   pass_count, fail_index   tests passed this run; first failing index (all-ones if none)
//   timeout_err              sticky: some test in this run hit the watchdog
module test_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_TESTS  = 10,
  parameter int TIMEOUT    = 15,
  parameter int TMR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] test,
  output logic                  dut_start,
  input  logic                  dut_done,
  input  logic                  dut_pass,
  output logic                  busy,
  output logic                  done,
  output logic                  result,
  output logic [ADDR_WIDTH:0]   pass_count,
  output logic [ADDR_WIDTH-1:0] fail_index,
  output logic                  timeout_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_TEST = ADDR_WIDTH'(NUM_TESTS - 1);
  localparam logic [ADDR_WIDTH-1:0] NO_FAIL   = '1;
  localparam logic [TMR_WIDTH-1:0]  TMR_LAST  = TMR_WIDTH'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH:0]   PASS_ALL  = (ADDR_WIDTH + 1)'(NUM_TESTS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [TMR_WIDTH-1:0]    timer, timer_n;
  logic [ADDR_WIDTH-1:0]   test_n, fail_n;
  logic [ADDR_WIDTH:0]     pass_n;
  logic                    tmo_n, done_n, result_n, dut_start_n, busy_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      test        <= '0;
      dut_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 1'b0;
      pass_count  <= '0;
      fail_index  <= NO_FAIL;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      test        <= test_n;
      dut_start   <= dut_start_n;
      busy        <= busy_n;
      done        <= done_n;
      result      <= result_n;
      pass_count  <= pass_n;
      fail_index  <= fail_n;
      timeout_err <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    test_n   = test;
    pass_n   = pass_count;
    fail_n   = fail_index;
    tmo_n    = timeout_err;
    done_n   = done;
    result_n = result;

    case (state)
      IDLE: begin
        if (start) begin
          test_n  = '0;
          pass_n  = '0;
          fail_n  = NO_FAIL;
          tmo_n   = 1'b0;
          done_n  = 1'b0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // dut_done takes priority over a watchdog expiry in the same cycle.
        if (dut_done) begin
          if (dut_pass) begin
            pass_n = pass_count + 1'b1;
          end else if (fail_index == NO_FAIL) begin
            fail_n = test;
          end
          state_n = NEXT;
        end else if (timer == TMR_LAST) begin
          if (fail_index == NO_FAIL) begin
            fail_n = test;
          end
          tmo_n   = 1'b1;
          state_n = NEXT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      NEXT: begin
        if (test == LAST_TEST) begin
          // pass_count and timeout_err are final here, so result is registered
          // together with done on entry to FINISH.
          done_n   = 1'b1;
          result_n = (pass_count == PASS_ALL) && !timeout_err;
          state_n  = FINISH;
        end else begin
          test_n  = test + 1'b1;
          state_n = ISSUE;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Registered outputs that simply track the state being entered.
    dut_start_n = (state_n == ISSUE);
    busy_n      = (state_n != IDLE);
  end

endmodule
